// File: rtl/sat_central_ctrl_p_pkg.sv
// Shared types for the SAT central controller.
// Struct field widths follow the default-sized instance.
package sat_ctrl_pkg;

  localparam int DEF_VAR_NUM    = 8;
  localparam int DEF_CLAUSE_NUM = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_CONFL  = 1024;
  localparam int DEF_VAR_LOG    = $clog2(DEF_VAR_NUM);
  localparam int DEF_CLAUSE_LOG = $clog2(DEF_CLAUSE_NUM);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_DECIDE,
    ST_BCP,
    ST_BACKTRACK,
    ST_DONE
  } ctrl_state_e;

  typedef struct packed {
    logic                   en;
    logic                   write;
    logic                   bcp_write;
    logic [DEF_VAR_LOG-1:0] addr;
    logic [DEF_VAR_LOG-1:0] free_bit;
    logic [DEF_VAR_NUM-1:0] wdata;
  } vst_req_t;

  typedef struct packed {
    logic                   en;
    logic                   write;
    logic [DEF_VAR_NUM-1:0] addr;
  } cdb_req_t;

  typedef struct packed {
    logic                      en;
    logic                      write;
    logic [DEF_CLAUSE_LOG-1:0] addr;
  } dm_req_t;

endpackage

// File: rtl/sat_central_ctrl_p_if.sv
// Engine handshake bundle between the central controller
// and the init/decide/BCP/backtrack engines.
interface sat_ctrl_if import sat_ctrl_pkg::*; #(
  parameter int VAR_NUM       = DEF_VAR_NUM,
  parameter int MAX_CONFLICTS = DEF_MAX_CONFL
);
  localparam int LVL_W = $clog2(VAR_NUM + 1);
  localparam int CNT_W = $clog2(MAX_CONFLICTS + 1);

  logic             sat_start;
  logic             initial_finish;
  logic             decide_done;
  logic             decide_all_assigned;
  logic             bcp_done;
  logic             bcp_conflict;
  logic             backtrack_done;
  logic             bt_exhausted;
  logic [LVL_W-1:0] bt_new_level;

  logic             initial_request;
  logic             decide_request;
  logic             bcp_request;
  logic             backtrack_request;
  logic [LVL_W-1:0] decision_level;
  logic [CNT_W-1:0] conflict_count;
  logic             sat_finish;
  logic             sat;
  logic             abort;

  modport master (
    input  sat_start, initial_finish,
    input  decide_done, decide_all_assigned,
    input  bcp_done, bcp_conflict,
    input  backtrack_done, bt_exhausted,
    input  bt_new_level,
    output initial_request, decide_request,
    output bcp_request, backtrack_request,
    output decision_level, conflict_count,
    output sat_finish, sat, abort
  );

  modport slave (
    output sat_start, initial_finish,
    output decide_done, decide_all_assigned,
    output bcp_done, bcp_conflict,
    output backtrack_done, bt_exhausted,
    output bt_new_level,
    input  initial_request, decide_request,
    input  bcp_request, backtrack_request,
    input  decision_level, conflict_count,
    input  sat_finish, sat, abort
  );

endinterface

// File: rtl/sat_central_ctrl_p_mux.sv
// State-selected grant of VST, clause_db and data_mem
// to one engine; read data returns only to the owner.
module sat_mem_grant_mux import sat_ctrl_pkg::*; #(
  parameter int VAR_NUM    = DEF_VAR_NUM,
  parameter int CLAUSE_NUM = DEF_CLAUSE_NUM,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  ctrl_state_e           state_i,
  input  vst_req_t              dec_vst_req_i,
  input  vst_req_t              bcp_vst_req_i,
  input  vst_req_t              bt_vst_req_i,
  output vst_req_t              vst_req_o,
  input  logic [VAR_NUM-1:0]    vst_rdata_i,
  output logic [VAR_NUM-1:0]    dec_vst_rdata_o,
  output logic [VAR_NUM-1:0]    bcp_vst_rdata_o,
  output logic [VAR_NUM-1:0]    bt_vst_rdata_o,
  input  cdb_req_t              bcp_cdb_req_i,
  output cdb_req_t              cdb_req_o,
  input  logic [CLAUSE_NUM-1:0] cdb_rdata_i,
  output logic [CLAUSE_NUM-1:0] bcp_cdb_rdata_o,
  input  dm_req_t               init_dm_req_i,
  output dm_req_t               dm_req_o,
  input  logic [DATA_W-1:0]     dm_rdata_i,
  output logic [DATA_W-1:0]     init_dm_rdata_o
);

  always_comb begin
    vst_req_o       = '0;
    cdb_req_o       = '0;
    dm_req_o        = '0;
    dec_vst_rdata_o = '0;
    bcp_vst_rdata_o = '0;
    bt_vst_rdata_o  = '0;
    bcp_cdb_rdata_o = '0;
    init_dm_rdata_o = '0;
    unique case (state_i)
      ST_INIT: begin
        dm_req_o        = init_dm_req_i;
        init_dm_rdata_o = dm_rdata_i;
      end
      ST_DECIDE: begin
        vst_req_o       = dec_vst_req_i;
        dec_vst_rdata_o = vst_rdata_i;
      end
      ST_BCP: begin
        vst_req_o       = bcp_vst_req_i;
        bcp_vst_rdata_o = vst_rdata_i;
        cdb_req_o       = bcp_cdb_req_i;
        bcp_cdb_rdata_o = cdb_rdata_i;
      end
      ST_BACKTRACK: begin
        vst_req_o      = bt_vst_req_i;
        bt_vst_rdata_o = vst_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sat_central_ctrl_p.sv
// Central controller: init/decide/BCP/backtrack sequencing,
// decision level and conflict budget tracking.
module sat_central_ctrl_p import sat_ctrl_pkg::*; #(
  parameter int VAR_NUM       = DEF_VAR_NUM,
  parameter int CLAUSE_NUM    = DEF_CLAUSE_NUM,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_CONFLICTS = DEF_MAX_CONFL
) (
  input  logic                  clk,
  input  logic                  rst,
  sat_ctrl_if.master            ctl,
  input  vst_req_t              dec_vst_req,
  input  vst_req_t              bcp_vst_req,
  input  vst_req_t              bt_vst_req,
  output vst_req_t              vst_req,
  input  logic [VAR_NUM-1:0]    vst_rdata,
  output logic [VAR_NUM-1:0]    dec_vst_rdata,
  output logic [VAR_NUM-1:0]    bcp_vst_rdata,
  output logic [VAR_NUM-1:0]    bt_vst_rdata,
  input  cdb_req_t              bcp_cdb_req,
  output cdb_req_t              cdb_req,
  input  logic [CLAUSE_NUM-1:0] cdb_rdata,
  output logic [CLAUSE_NUM-1:0] bcp_cdb_rdata,
  input  dm_req_t               init_dm_req,
  output dm_req_t               dm_req,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic [DATA_W-1:0]     init_dm_rdata
);

  localparam int LVL_W = $clog2(VAR_NUM + 1);
  localparam int CNT_W = $clog2(MAX_CONFLICTS + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(VAR_NUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONFLICTS);

  ctrl_state_e      state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d, lvl_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sat_q, sat_d;
  logic             abort_q, abort_d;
  logic             ireq_q, ireq_d;
  logic             dreq_q, dreq_d;
  logic             breq_q, breq_d;
  logic             treq_q, treq_d;

  assign lvl_inc = (lvl_q == LVL_MAX) ? lvl_q : lvl_q + 1'b1;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    abort_d = abort_q;
    ireq_d  = 1'b0;
    dreq_d  = 1'b0;
    breq_d  = 1'b0;
    treq_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (ctl.sat_start) begin
        state_d = ST_INIT;
        lvl_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        abort_d = 1'b0;
        ireq_d  = 1'b1;
      end
      ST_INIT: if (ctl.initial_finish) begin
        state_d = ST_DECIDE;
        dreq_d  = 1'b1;
      end
      ST_DECIDE: if (ctl.decide_done) begin
        if (ctl.decide_all_assigned) begin
          state_d = ST_DONE;
          sat_d   = 1'b1;
        end else begin
          state_d = ST_BCP;
          lvl_d   = lvl_inc;
          breq_d  = 1'b1;
        end
      end
      ST_BCP: if (ctl.bcp_done) begin
        if (!ctl.bcp_conflict) begin
          state_d = ST_DECIDE;
          dreq_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          // A root-level conflict wins over the budget check
          if (lvl_q == '0) begin
            state_d = ST_DONE;
            sat_d   = 1'b0;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = ST_DONE;
            sat_d   = 1'b0;
            abort_d = 1'b1;
          end else begin
            state_d = ST_BACKTRACK;
            treq_d  = 1'b1;
          end
        end
      end
      ST_BACKTRACK: if (ctl.backtrack_done) begin
        if (ctl.bt_exhausted) begin
          state_d = ST_DONE;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_BCP;
          lvl_d   = ctl.bt_new_level;
          breq_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      abort_q <= 1'b0;
      ireq_q  <= 1'b0;
      dreq_q  <= 1'b0;
      breq_q  <= 1'b0;
      treq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      abort_q <= abort_d;
      ireq_q  <= ireq_d;
      dreq_q  <= dreq_d;
      breq_q  <= breq_d;
      treq_q  <= treq_d;
    end
  end

  assign ctl.initial_request   = ireq_q;
  assign ctl.decide_request    = dreq_q;
  assign ctl.bcp_request       = breq_q;
  assign ctl.backtrack_request = treq_q;
  assign ctl.decision_level    = lvl_q;
  assign ctl.conflict_count    = cnt_q;
  assign ctl.sat_finish        = (state_q == ST_DONE);
  assign ctl.sat               = sat_q;
  assign ctl.abort             = abort_q;

  sat_mem_grant_mux #(
    .VAR_NUM    (VAR_NUM),
    .CLAUSE_NUM (CLAUSE_NUM),
    .DATA_W     (DATA_W)
  ) u_grant (
    .state_i         (state_q),
    .dec_vst_req_i   (dec_vst_req),
    .bcp_vst_req_i   (bcp_vst_req),
    .bt_vst_req_i    (bt_vst_req),
    .vst_req_o       (vst_req),
    .vst_rdata_i     (vst_rdata),
    .dec_vst_rdata_o (dec_vst_rdata),
    .bcp_vst_rdata_o (bcp_vst_rdata),
    .bt_vst_rdata_o  (bt_vst_rdata),
    .bcp_cdb_req_i   (bcp_cdb_req),
    .cdb_req_o       (cdb_req),
    .cdb_rdata_i     (cdb_rdata),
    .bcp_cdb_rdata_o (bcp_cdb_rdata),
    .init_dm_req_i   (init_dm_req),
    .dm_req_o        (dm_req),
    .dm_rdata_i      (dm_rdata),
    .init_dm_rdata_o (init_dm_rdata)
  );

endmodule

// File: tb/tb_sat_central_ctrl_p.sv
// Bench for sat_central_ctrl_p: directed table, corner
// sequences and a randomized run against a phase model.
module tb_sat_central_ctrl_p;
  import sat_ctrl_pkg::*;

  localparam int MAXC = 2;
  localparam int VN   = 8;

  typedef struct packed {
    logic rst, start, ifin, ddone, dall;
    logic bdone, bconf, btdone, btex;
    logic [3:0] nl;
  } in_t;

  typedef struct {
    logic [7:0] b;
    int         nl;
    int         lvl;
    int         cnt;
    logic [2:0] fsa;
    logic [3:0] pul;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  sat_ctrl_if #(.VAR_NUM(VN), .MAX_CONFLICTS(MAXC)) ifc ();

  vst_req_t    dec_vst, bcp_vst, bt_vst, vst_o;
  logic [7:0]  vst_rd, dec_rd, bcp_rd, bt_rd;
  cdb_req_t    bcp_cdb, cdb_o;
  logic [15:0] cdb_rd, bcp_cdb_rd;
  dm_req_t     init_dm, dm_o;
  logic [31:0] dm_rd, init_dm_rd;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl[$];

  string      mph;
  int         mlvl, mcnt;
  bit         msat, mab;
  bit [3:0]   mpul;

  sat_central_ctrl_p #(.MAX_CONFLICTS(MAXC)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctl           (ifc),
    .dec_vst_req   (dec_vst),
    .bcp_vst_req   (bcp_vst),
    .bt_vst_req    (bt_vst),
    .vst_req       (vst_o),
    .vst_rdata     (vst_rd),
    .dec_vst_rdata (dec_rd),
    .bcp_vst_rdata (bcp_rd),
    .bt_vst_rdata  (bt_rd),
    .bcp_cdb_req   (bcp_cdb),
    .cdb_req       (cdb_o),
    .cdb_rdata     (cdb_rd),
    .bcp_cdb_rdata (bcp_cdb_rd),
    .init_dm_req   (init_dm),
    .dm_req        (dm_o),
    .dm_rdata      (dm_rd),
    .init_dm_rdata (init_dm_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic vec_t V(input logic [7:0] b, input int nl,
                             input int lvl, input int cnt,
                             input logic [2:0] fsa,
                             input logic [3:0] pul);
    vec_t v;
    v.b = b; v.nl = nl; v.lvl = lvl; v.cnt = cnt;
    v.fsa = fsa; v.pul = pul;
    return v;
  endfunction

  function automatic in_t mk(input logic [7:0] b, input int nl);
    in_t x;
    x = '0;
    {x.start, x.ifin, x.ddone, x.dall,
     x.bdone, x.bconf, x.btdone, x.btex} = b;
    x.nl = nl[3:0];
    return x;
  endfunction

  task automatic drive(input in_t x);
    rst                     = x.rst;
    ifc.sat_start           = x.start;
    ifc.initial_finish      = x.ifin;
    ifc.decide_done         = x.ddone;
    ifc.decide_all_assigned = x.dall;
    ifc.bcp_done            = x.bdone;
    ifc.bcp_conflict        = x.bconf;
    ifc.backtrack_done      = x.btdone;
    ifc.bt_exhausted        = x.btex;
    ifc.bt_new_level        = x.nl;
  endtask

  task automatic tick(input in_t x);
    drive(x);
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string t, input int lvl, input int cnt,
                         input logic [2:0] fsa, input logic [3:0] pul);
    chk({t, ".lvl"}, 64'(ifc.decision_level), 64'(lvl));
    chk({t, ".cnt"}, 64'(ifc.conflict_count), 64'(cnt));
    chk({t, ".fin_sat_abort"},
        64'({ifc.sat_finish, ifc.sat, ifc.abort}), 64'(fsa));
    chk({t, ".pulses"},
        64'({ifc.initial_request, ifc.decide_request,
             ifc.bcp_request, ifc.backtrack_request}), 64'(pul));
  endtask

  // Solver loop rules expressed over named phases
  task automatic mstep(input in_t x);
    mpul = 4'b0000;
    if (x.rst) begin
      mph = "IDLE"; mlvl = 0; mcnt = 0; msat = 0; mab = 0;
      return;
    end
    if (mph == "IDLE" || mph == "DONE") begin
      if (x.start) begin
        mph = "INIT"; mlvl = 0; mcnt = 0; msat = 0; mab = 0;
        mpul = 4'b1000;
      end
    end else if (mph == "INIT") begin
      if (x.ifin) begin mph = "DECIDE"; mpul = 4'b0100; end
    end else if (mph == "DECIDE") begin
      if (x.ddone) begin
        if (x.dall) begin mph = "DONE"; msat = 1; end
        else begin
          mph = "BCP"; mpul = 4'b0010;
          mlvl = (mlvl + 1 > VN) ? VN : mlvl + 1;
        end
      end
    end else if (mph == "BCP") begin
      if (x.bdone) begin
        if (!x.bconf) begin mph = "DECIDE"; mpul = 4'b0100; end
        else begin
          mcnt = (mcnt + 1 > MAXC) ? MAXC : mcnt + 1;
          if (mlvl == 0) mph = "DONE";
          else if (mcnt == MAXC) begin mph = "DONE"; mab = 1; end
          else begin mph = "BACKTRACK"; mpul = 4'b0001; end
        end
      end
    end else if (mph == "BACKTRACK") begin
      if (x.btdone) begin
        if (x.btex) mph = "DONE";
        else begin mph = "BCP"; mlvl = int'(x.nl); mpul = 4'b0010; end
      end
    end
  endtask

  task automatic gchk(input string t);
    vst_req_t ev;
    ev = '0;
    if (mph == "DECIDE") ev = dec_vst;
    else if (mph == "BCP") ev = bcp_vst;
    else if (mph == "BACKTRACK") ev = bt_vst;
    chk({t, ".vst_req"}, 64'(vst_o), 64'(ev));
    chk({t, ".dec_rd"}, 64'(dec_rd), mph == "DECIDE" ? 64'(vst_rd) : 0);
    chk({t, ".bcp_rd"}, 64'(bcp_rd), mph == "BCP" ? 64'(vst_rd) : 0);
    chk({t, ".bt_rd"}, 64'(bt_rd), mph == "BACKTRACK" ? 64'(vst_rd) : 0);
    chk({t, ".cdb_req"}, 64'(cdb_o), mph == "BCP" ? 64'(bcp_cdb) : 0);
    chk({t, ".cdb_rd"}, 64'(bcp_cdb_rd), mph == "BCP" ? 64'(cdb_rd) : 0);
    chk({t, ".dm_req"}, 64'(dm_o), mph == "INIT" ? 64'(init_dm) : 0);
    chk({t, ".dm_rd"}, 64'(init_dm_rd), mph == "INIT" ? 64'(dm_rd) : 0);
  endtask

  task automatic rand_mem();
    logic [31:0] r;
    r = $urandom; dec_vst = r[$bits(vst_req_t)-1:0];
    r = $urandom; bcp_vst = r[$bits(vst_req_t)-1:0];
    r = $urandom; bt_vst  = r[$bits(vst_req_t)-1:0];
    r = $urandom; bcp_cdb = r[$bits(cdb_req_t)-1:0];
    r = $urandom; init_dm = r[$bits(dm_req_t)-1:0];
    r = $urandom; vst_rd  = r[7:0];
    r = $urandom; cdb_rd  = r[15:0];
    dm_rd = $urandom;
  endtask

  initial begin
    in_t x;
    dec_vst = '0; bcp_vst = '0; bt_vst = '0; bcp_cdb = '0;
    init_dm = '0; vst_rd = '0; cdb_rd = '0; dm_rd = '0;
    x = '0; x.rst = 1'b1;
    tick(x);
    tick(x);
    tick(mk(8'h00, 0));
    exp_out("reset", 0, 0, 3'b000, 4'b0000);

    // SAT path, with stray done inputs outside their state
    tbl.push_back(V(8'h80, 0, 0, 0, 3'b000, 4'b1000));
    tbl.push_back(V(8'h20, 0, 0, 0, 3'b000, 4'b0000));
    tbl.push_back(V(8'h40, 0, 0, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h20, 0, 1, 0, 3'b000, 4'b0010));
    tbl.push_back(V(8'h08, 0, 1, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h20, 0, 2, 0, 3'b000, 4'b0010));
    tbl.push_back(V(8'h08, 0, 2, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h30, 0, 2, 0, 3'b110, 4'b0000));
    tbl.push_back(V(8'h0C, 0, 2, 0, 3'b110, 4'b0000));
    // root-level conflict beats the budget check
    tbl.push_back(V(8'h80, 0, 0, 0, 3'b000, 4'b1000));
    tbl.push_back(V(8'h40, 0, 0, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h20, 0, 1, 0, 3'b000, 4'b0010));
    tbl.push_back(V(8'h0C, 0, 1, 1, 3'b000, 4'b0001));
    tbl.push_back(V(8'h08, 0, 1, 1, 3'b000, 4'b0000));
    tbl.push_back(V(8'h02, 0, 0, 1, 3'b000, 4'b0010));
    tbl.push_back(V(8'h0C, 0, 0, 2, 3'b100, 4'b0000));
    // backtrack to level 2, then budget abort
    tbl.push_back(V(8'h80, 0, 0, 0, 3'b000, 4'b1000));
    tbl.push_back(V(8'h40, 0, 0, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h20, 0, 1, 0, 3'b000, 4'b0010));
    tbl.push_back(V(8'h08, 0, 1, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h20, 0, 2, 0, 3'b000, 4'b0010));
    tbl.push_back(V(8'h08, 0, 2, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h20, 0, 3, 0, 3'b000, 4'b0010));
    tbl.push_back(V(8'h0C, 0, 3, 1, 3'b000, 4'b0001));
    tbl.push_back(V(8'h02, 2, 2, 1, 3'b000, 4'b0010));
    tbl.push_back(V(8'h0C, 0, 2, 2, 3'b101, 4'b0000));
    tbl.push_back(V(8'h00, 0, 2, 2, 3'b101, 4'b0000));
    // exhausted backtrack leaves the level untouched
    tbl.push_back(V(8'h80, 0, 0, 0, 3'b000, 4'b1000));
    tbl.push_back(V(8'h40, 0, 0, 0, 3'b000, 4'b0100));
    tbl.push_back(V(8'h20, 0, 1, 0, 3'b000, 4'b0010));
    tbl.push_back(V(8'h0C, 0, 1, 1, 3'b000, 4'b0001));
    tbl.push_back(V(8'h03, 5, 1, 1, 3'b100, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      tick(mk(tbl[i].b, tbl[i].nl));
      exp_out($sformatf("tbl%0d", i), tbl[i].lvl, tbl[i].cnt,
              tbl[i].fsa, tbl[i].pul);
    end

    // Level saturates at VAR_NUM
    tick(mk(8'h80, 0));
    tick(mk(8'h40, 0));
    for (int i = 0; i < 10; i++) begin
      tick(mk(8'h20, 0));
      chk($sformatf("satlvl%0d", i), 64'(ifc.decision_level),
          64'((i + 1 > VN) ? VN : i + 1));
      tick(mk(8'h08, 0));
    end
    tick(mk(8'h20, 0));
    exp_out("lvl_hold", 8, 0, 3'b000, 4'b0010);
    tick(mk(8'h0C, 0));
    exp_out("bt8", 8, 1, 3'b000, 4'b0001);
    tick(mk(8'h02, 3));
    exp_out("bcp3", 3, 1, 3'b000, 4'b0010);

    // BCP owns VST/clause_db; decide traffic is ignored
    dec_vst = '0; dec_vst.en = 1'b1; dec_vst.addr = 3'd5;
    bcp_vst = '0; bcp_vst.en = 1'b1; bcp_vst.write = 1'b1;
    bcp_vst.addr = 3'd2; bcp_vst.wdata = 8'h3C;
    bt_vst = '0; bt_vst.en = 1'b1;
    bcp_cdb = '0; bcp_cdb.en = 1'b1; bcp_cdb.addr = 8'h77;
    init_dm = '0; init_dm.en = 1'b1;
    vst_rd = 8'hA5; cdb_rd = 16'h1234; dm_rd = 32'hDEADBEEF;
    drive(mk(8'h20, 0));
    #1;
    chk("g.vst_req", 64'(vst_o), 64'(bcp_vst));
    chk("g.dec_rd", 64'(dec_rd), 64'(0));
    chk("g.bcp_rd", 64'(bcp_rd), 64'(8'hA5));
    chk("g.bt_rd", 64'(bt_rd), 64'(0));
    chk("g.cdb_req", 64'(cdb_o), 64'(bcp_cdb));
    chk("g.cdb_rd", 64'(bcp_cdb_rd), 64'(16'h1234));
    chk("g.dm_req", 64'(dm_o), 64'(0));
    chk("g.dm_rd", 64'(init_dm_rd), 64'(0));
    tick(mk(8'h20, 0));
    exp_out("ign_dec", 3, 1, 3'b000, 4'b0000);

    // Reset while BCP reports a conflict
    x = mk(8'h0C, 0); x.rst = 1'b1;
    tick(x);
    exp_out("rst_bcp", 0, 0, 3'b000, 4'b0000);
    chk("rst_bcp.vst_req", 64'(vst_o), 64'(0));
    tick(mk(8'h0C, 0));
    exp_out("post_rst", 0, 0, 3'b000, 4'b0000);

    // Randomized run against the phase model
    x = '0; x.rst = 1'b1;
    tick(x);
    mstep(x);
    for (int c = 0; c < 3000; c++) begin
      x.rst    = ($urandom_range(0, 199) == 0);
      x.start  = ($urandom_range(0, 9) < 3);
      x.ifin   = ($urandom_range(0, 9) < 4);
      x.ddone  = ($urandom_range(0, 9) < 4);
      x.dall   = ($urandom_range(0, 3) == 0);
      x.bdone  = ($urandom_range(0, 9) < 4);
      x.bconf  = ($urandom_range(0, 9) < 3);
      x.btdone = ($urandom_range(0, 9) < 4);
      x.btex   = ($urandom_range(0, 9) < 2);
      x.nl     = 4'($urandom_range(0, VN));
      rand_mem();
      drive(x);
      #1;
      gchk($sformatf("r%0d", c));
      @(posedge clk);
      #1;
      mstep(x);
      exp_out($sformatf("r%0d", c), mlvl, mcnt,
              {mph == "DONE", msat, mab}, mpul);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
